pc_sequencer: RTL and testbench

Program-counter sequencer for the picoMIPS core. It owns the instruction address register and decides every cycle whether the PC increments, holds, branches or halts. The decoder supplies per-instruction control; an external push-button `flag` resumes execution after a wait instruction. The block sits between the instruction decoder and the program memory address port.

---
 rtl/picomips_pkg.sv | 8 +
 rtl/flag_debounce.sv | 43 ++++
 rtl/pc_sequencer.sv | 85 ++++++++
 tb/tb_pc_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/picomips_pkg.sv
// Shared types and defaults for the picoMIPS program-counter sequencer.
package picomips_pkg;

  typedef enum logic [1:0] {RUN, WAIT, HALT} seq_state_t;

  localparam int unsigned PsizeDefault = 6;

endpackage

// File: rtl/flag_debounce.sv
// Push-button conditioner: 2-flop synchroniser, DEB-cycle debounce counter and a
// one-cycle press pulse on the rising edge of the debounced level.
module flag_debounce #(
  parameter int unsigned DEB = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic flag,
  output logic press
);

  localparam int unsigned CntW = (DEB > 1) ? $clog2(DEB) : 1;

  logic            sync1_q, sync2_q;
  logic            level_q, level_prev_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= flag;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      // Any sample agreeing with the debounced level restarts the count.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(DEB - 1)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press = level_q & ~level_prev_q;

endmodule

// File: rtl/pc_sequencer.sv
// picoMIPS PC sequencer: RUN/WAIT/HALT control of the instruction address.
// Relative branches are only honoured when PC_BRANCH_EN is defined.
module pc_sequencer
  import picomips_pkg::*;
#(
  parameter int unsigned Psize = PsizeDefault,
  parameter int unsigned DEB   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flag,
  input  logic             wait_req,
  input  logic             halt_req,
  input  logic             branch_req,
  input  logic [Psize-1:0] branch_off,
  output logic [Psize-1:0] PCout,
  output logic             advance,
  output logic             waiting,
  output logic             halted
);

  seq_state_t       state_q, state_d;
  logic [Psize-1:0] pc_q, pc_d;
  logic             press;

  flag_debounce #(
    .DEB(DEB)
  ) u_flag_debounce (
    .clk  (clk),
    .reset(reset),
    .flag (flag),
    .press(press)
  );

`ifndef PC_BRANCH_EN
  logic unused_branch;
  assign unused_branch = ^{branch_req, branch_off};
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    advance = 1'b0;
    case (state_q)
      RUN: begin
        if (halt_req) begin
          state_d = HALT;
        end else if (wait_req) begin
          state_d = WAIT;
        end else begin
          pc_d    = pc_q + Psize'(1);
`ifdef PC_BRANCH_EN
          if (branch_req) pc_d = pc_q + Psize'(1) + branch_off;
`endif
          // Flagged explicitly: a branch of -1 lands on the same address.
          advance = 1'b1;
        end
      end
      WAIT: begin
        if (press) begin
          pc_d    = pc_q + Psize'(1);
          state_d = RUN;
          advance = 1'b1;
        end
      end
      HALT: ;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign PCout   = pc_q;
  assign waiting = (state_q == WAIT);
  assign halted  = (state_q == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a cycle-level reference model.
module tb_pc_sequencer;

  localparam int P   = 6;
  localparam int DEB = 4;
  localparam int MOD = 1 << P;

  logic         clk = 1'b0;
  logic         reset, flag, wait_req, halt_req, branch_req;
  logic [P-1:0] branch_off;
  logic [P-1:0] PCout;
  logic         advance, waiting, halted;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  pc_sequencer #(
    .Psize(P),
    .DEB  (DEB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flag      (flag),
    .wait_req  (wait_req),
    .halt_req  (halt_req),
    .branch_req(branch_req),
    .branch_off(branch_off),
    .PCout     (PCout),
    .advance   (advance),
    .waiting   (waiting),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = RUN, 1 = WAIT, 2 = HALT.
  int m_pc, m_mode, m_streak;
  bit m_level, m_press, m_sync;
  bit hist[$];

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 0; m_mode = 0; m_level = 0; m_streak = 0; m_press = 0;
      hist = {1'b0, 1'b0};
    end else begin
      if (m_mode == 0) begin
        if (halt_req) m_mode = 2;
        else if (wait_req) m_mode = 1;
        else begin
          int off;
          off = 0;
`ifdef PC_BRANCH_EN
          if (branch_req) off = $signed(branch_off);
`endif
          m_pc = (((m_pc + 1 + off) % MOD) + MOD) % MOD;
        end
      end else if (m_mode == 1 && m_press) begin
        m_pc = (m_pc + 1) % MOD;
        m_mode = 0;
      end
      // Synchronised sample seen now is the flag captured two edges ago.
      hist.push_front(flag);
      m_sync = hist[2];
      if (hist.size() > 3) void'(hist.pop_back());
      m_press = 0;
      if (m_sync != m_level) begin
        m_streak++;
        if (m_streak == DEB) begin
          m_level = m_sync;
          m_streak = 0;
          m_press = m_level;
        end
      end else m_streak = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int exp_adv;
      exp_adv = (m_mode == 0) ? int'(!(halt_req || wait_req)) : (m_mode == 1) ? int'(m_press) : 0;
      check("pc", int'(PCout), m_pc);
      check("waiting", int'(waiting), int'(m_mode == 1));
      check("halted", int'(halted), int'(m_mode == 2));
      check("advance", int'(advance), exp_adv);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int first_change;
    reset = 1; flag = 0; wait_req = 0; halt_req = 0; branch_req = 0; branch_off = '0;
    tick(1);
    chk_en = 1;
    tick(1);
    reset = 0;
    check("reset_pc", int'(PCout), 0);
    check("reset_waiting", int'(waiting), 0);
    check("reset_halted", int'(halted), 0);
    check("reset_advance", int'(advance), 1);

    // Free run through wrap.
    tick(70);
    check("wrap_pc", int'(PCout), 6);

    // Wait released by a held press.
    reset = 1; tick(1); reset = 0;
    tick(5);
    wait_req = 1; tick(1); wait_req = 0;
    check("wait_hold_pc", int'(PCout), 5);
    check("wait_flag", int'(waiting), 1);
    flag = 1;
    first_change = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (first_change == 0 && PCout != 6'd5) first_change = k;
    end
    check("release_edge", first_change, DEB + 3);
    check("after_release_pc", int'(PCout), 19);
    flag = 0; tick(10);
    check("release_no_event_pc", int'(PCout), 29);

    // Short glitch, then bounces followed by a hold.
    wait_req = 1; tick(1); wait_req = 0;
    flag = 1; tick(DEB - 1); flag = 0; tick(10);
    check("glitch_pc", int'(PCout), 29);
    check("glitch_waiting", int'(waiting), 1);
    for (int i = 0; i < 6; i++) begin
      flag = (i % 2 == 0);
      tick(1);
    end
    flag = 1; tick(6);
    check("bounce_hold_pc", int'(PCout), 29);
    check("bounce_hold_waiting", int'(waiting), 1);
    tick(1);
    check("bounce_release_pc", int'(PCout), 30);
    check("bounce_release_waiting", int'(waiting), 0);
    flag = 0; tick(10);

    // Halt beats wait; only reset leaves.
    reset = 1; tick(1); reset = 0;
    tick(10);
    halt_req = 1; wait_req = 1; tick(1); halt_req = 0; wait_req = 0;
    check("halt_flag", int'(halted), 1);
    flag = 1; tick(20); flag = 0; tick(30);
    check("halt_pc", int'(PCout), 10);
    reset = 1; tick(1); reset = 0;
    check("halt_reset_pc", int'(PCout), 0);
    check("halt_reset_halted", int'(halted), 0);

    // Relative branches with wrap in both directions.
    tick(2);
    branch_req = 1; branch_off = 6'h3d; tick(1); branch_req = 0;
`ifdef PC_BRANCH_EN
    check("branch_back_pc", int'(PCout), 0);
    tick(62);
`else
    check("branch_back_pc", int'(PCout), 3);
    tick(59);
`endif
    branch_req = 1; branch_off = 6'd5; tick(1); branch_req = 0; branch_off = '0;
`ifdef PC_BRANCH_EN
    check("branch_fwd_pc", int'(PCout), 4);
`else
    check("branch_fwd_pc", int'(PCout), 63);
`endif

    // Reset in the middle of a debounce while waiting.
    wait_req = 1; tick(1); wait_req = 0;
    flag = 1; tick(3);
    reset = 1; tick(1); reset = 0;
    check("midreset_pc", int'(PCout), 0);
    check("midreset_waiting", int'(waiting), 0);
    tick(10);
    check("held_flag_run_pc", int'(PCout), 10);
    flag = 0; tick(8);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
